// File: rtl/pixel_sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the pixel sort controller:
//   KEY_W   - fixed pixel key width (16)
//   state_e - controller states LOAD / SORT / DRAIN
//   clog2   - index width helper for the key buffer
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int KEY_W = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Smallest r with 2**r >= n (minimum 1 so index vectors never collapse).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_sort_ctrl_if.sv
// -----------------------------------------------------------------------------
// pixel_sort_ctrl_if
// Key streams around the sort controller.
//   in_valid / in_ready / in_data            : unsorted keys into the block
//   out_valid / out_ready / out_data / out_last : sorted keys out of the block
// master : the environment (fetch stage + image writer)
// slave  : the sort controller
// -----------------------------------------------------------------------------
interface pixel_sort_ctrl_if;
  import sort_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [KEY_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pixel_sort_ctrl_compare16.sv
// -----------------------------------------------------------------------------
// compare16
// Combinational unsigned magnitude comparator for two 16-bit keys.
//   A, B     in  : keys
//   Abigger  out : A > B
//   Bbigger  out : B > A   (both low when equal)
// -----------------------------------------------------------------------------
module compare16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        Abigger,
  output logic        Bbigger
);

  assign Abigger = (A > B);
  assign Bbigger = (B > A);

endmodule

// File: rtl/pixel_sort_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_sort_ctrl
// Buffers one frame of DEPTH keys, sorts it in place with an odd-even
// transposition sort (one compare16 query per cycle) and streams the keys out
// in ascending order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pixel_sort_ctrl_if.slave (input and output key streams)
//   busy       : high while in SORT or DRAIN
// Optional build macro: SORT_EARLY_EXIT_EN -- stop SORT after an even/odd pass
// pair that made no swaps (the buffer is already ordered at that point).
// -----------------------------------------------------------------------------
module pixel_sort_ctrl
  import sort_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_sort_ctrl_if.slave bus,
  output logic             busy
);

  localparam int IDX_W = clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX    = idx_t'(DEPTH - 1);
  localparam idx_t EVEN_LAST_J = idx_t'(DEPTH - 2);
  localparam idx_t ODD_LAST_J  = idx_t'(DEPTH - 3);

  state_e           state_q;
  logic [KEY_W-1:0] mem_q [DEPTH];
  idx_t             wr_idx_q;
  idx_t             rd_idx_q;
  idx_t             j_q;        // left element of the pair compared this cycle
  idx_t             pass_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [KEY_W-1:0] out_data_q;
  logic             busy_q;
`ifdef SORT_EARLY_EXIT_EN
  logic             swap_seen_q; // any swap in the current even/odd pass pair
`endif

  idx_t             j_nx_s;
  idx_t             rd_nx_s;
  logic [KEY_W-1:0] a_s;
  logic [KEY_W-1:0] b_s;
  logic             a_bigger_s;
  logic             b_bigger_s;
  logic             swap_s;
  logic             pass_end_s;
  logic             sort_done_s;

  assign j_nx_s  = j_q + idx_t'(1);
  assign rd_nx_s = rd_idx_q + idx_t'(1);
  assign a_s     = mem_q[j_q];
  assign b_s     = mem_q[j_nx_s];

  compare16 u_cmp (
    .A       (a_s),
    .B       (b_s),
    .Abigger (a_bigger_s),
    .Bbigger (b_bigger_s)
  );

  // Strict A>B only: equal keys never swap, keeping the sort stable.
  assign swap_s = (state_q == SORT) && a_bigger_s && !b_bigger_s;

  // Pass boundary and end-of-sort decode.
  always_comb begin
    pass_end_s  = 1'b0;
    sort_done_s = 1'b0;
    if (pass_q[0]) begin
      pass_end_s = (j_q == ODD_LAST_J);
    end else begin
      pass_end_s = (j_q == EVEN_LAST_J);
    end
    if (pass_end_s && (pass_q == LAST_IDX)) begin
      sort_done_s = 1'b1;
    end else if (pass_end_s && (DEPTH == 2)) begin
      // With two keys the odd passes are empty; one compare finishes the sort.
      sort_done_s = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
    end else if (pass_end_s && pass_q[0] && !swap_seen_q && !swap_s) begin
      sort_done_s = 1'b1;
`endif
    end else begin
      sort_done_s = 1'b0;
    end
  end

  // Controller FSM: load, in-place sort, drain with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      j_q         <= '0;
      pass_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swap_seen_q <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            mem_q[wr_idx_q] <= bus.in_data;
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_q    <= '0;
              state_q     <= SORT;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
              j_q         <= '0;
              pass_q      <= '0;
`ifdef SORT_EARLY_EXIT_EN
              swap_seen_q <= 1'b0;
`endif
            end else begin
              wr_idx_q <= wr_idx_q + idx_t'(1);
            end
          end
        end
        SORT: begin
          if (swap_s) begin
            mem_q[j_q]    <= b_s;
            mem_q[j_nx_s] <= a_s;
          end
`ifdef SORT_EARLY_EXIT_EN
          // The flag covers one even pass plus the odd pass after it.
          if (pass_end_s && pass_q[0]) begin
            swap_seen_q <= 1'b0;
          end else begin
            swap_seen_q <= swap_seen_q | swap_s;
          end
`endif
          if (sort_done_s) begin
            state_q <= DRAIN;
          end else if (pass_end_s) begin
            pass_q <= pass_q + idx_t'(1);
            j_q    <= pass_q[0] ? idx_t'(0) : idx_t'(1);
          end else begin
            j_q <= j_q + idx_t'(2);
          end
        end
        DRAIN: begin
          if (!out_valid_q) begin
            // First DRAIN cycle presents buf[0].
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_idx_q];
            out_last_q  <= (rd_idx_q == LAST_IDX);
          end else if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              rd_idx_q    <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= LOAD;
            end else begin
              rd_idx_q   <= rd_nx_s;
              out_data_q <= mem_q[rd_nx_s];
              out_last_q <= (rd_nx_s == LAST_IDX);
            end
          end else begin
            out_data_q <= out_data_q;
          end
        end
        default: begin
          state_q     <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;

endmodule
